// File: rtl/mold_msg_sequencer.sv
// mold_msg_sequencer: splits filtered Ethernet/IPv4/UDP/MoldUDP64 frames into
// individually framed messages, each tagged with its own sequence number.
module mold_msg_sequencer #(
    parameter logic [15:0] UDP_PORT = 16'h6720
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  data,
    input  logic        dataValid,
    output logic [7:0]  msgData,
    output logic        msgValid,
    output logic        msgStart,
    output logic        msgEnd,
    output logic [63:0] msgSeqNum,
    output logic        frameDrop,
    output logic        truncErr,
    output logic        seqGap
);
    typedef enum logic [2:0] {IDLE, HDR, LEN_HI, LEN_LO, BODY, DONE, DROP} stateT;
    stateT state, stateNext;
    logic [5:0]  offset, offsetNext;
    logic [63:0] seqNum, seqNumNext, nextSeq, nextSeqNext, msgSeqNumNext;
    logic        nextSeqValid, nextSeqValidNext, first, firstNext;
    logic [15:0] msgCnt, msgCntNext, msgIdx, msgIdxNext, remain, remainNext;
    logic [15:0] cntFull, lenFull, idxInc;
    logic [7:0]  lenHi, lenHiNext, msgDataNext;
    logic        msgValidNext, msgStartNext, msgEndNext;
    logic        frameDropNext, truncErrNext, seqGapNext, filterOk;

    assign cntFull = {msgCnt[15:8], data};
    assign lenFull = {lenHi, data};
    assign idxInc  = msgIdx + 16'd1;

    always_comb begin
        filterOk = 1'b1;
        case (offset)
            6'd12:   filterOk = data == 8'h08;
            6'd13:   filterOk = data == 8'h00;
            6'd14:   filterOk = data == 8'h45;
            6'd23:   filterOk = data == 8'h11;
            6'd36:   filterOk = data == UDP_PORT[15:8];
            6'd37:   filterOk = data == UDP_PORT[7:0];
            default: filterOk = 1'b1;
        endcase
    end

    always_comb begin
        stateNext        = state;
        offsetNext       = offset;
        seqNumNext       = seqNum;
        nextSeqNext      = nextSeq;
        nextSeqValidNext = nextSeqValid;
        msgCntNext       = msgCnt;
        msgIdxNext       = msgIdx;
        remainNext       = remain;
        lenHiNext        = lenHi;
        firstNext        = first;
        msgSeqNumNext    = msgSeqNum;
        msgDataNext      = 8'h00;
        msgValidNext     = 1'b0;
        msgStartNext     = 1'b0;
        msgEndNext       = 1'b0;
        frameDropNext    = 1'b0;
        truncErrNext     = 1'b0;
        seqGapNext       = 1'b0;
        case (state)
            IDLE: if (dataValid) begin
                stateNext  = HDR;
                offsetNext = 6'd1;
            end
            HDR: if (!dataValid) begin
                truncErrNext = 1'b1;
                stateNext    = IDLE;
            end else if (!filterOk) begin
                frameDropNext = 1'b1;
                stateNext     = DROP;
            end else begin
                offsetNext = offset == 6'd62 ? offset : offset + 6'd1;
                if (offset >= 6'd52 && offset <= 6'd59) seqNumNext = {seqNum[55:0], data};
                if (offset == 6'd60) msgCntNext[15:8] = data;
                if (offset == 6'd61) begin
                    msgCntNext       = cntFull;
                    msgIdxNext       = 16'd0;
                    seqGapNext       = nextSeqValid && seqNum != nextSeq;
                    // end-of-session count 0xFFFF carries no messages
                    nextSeqNext      = seqNum + {48'd0, cntFull == 16'hFFFF ? 16'd0 : cntFull};
                    nextSeqValidNext = 1'b1;
                    stateNext        = (cntFull == 16'd0 || cntFull == 16'hFFFF) ? DONE : LEN_HI;
                end
            end
            LEN_HI: if (!dataValid) begin
                truncErrNext = 1'b1;
                stateNext    = IDLE;
            end else begin
                lenHiNext = data;
                stateNext = LEN_LO;
            end
            LEN_LO: if (!dataValid) begin
                truncErrNext = 1'b1;
                stateNext    = IDLE;
            end else if (lenFull == 16'd0) begin
                msgIdxNext = idxInc;
                stateNext  = idxInc == msgCnt ? DONE : LEN_HI;
            end else begin
                remainNext = lenFull;
                firstNext  = 1'b1;
                stateNext  = BODY;
            end
            BODY: if (!dataValid) begin
                truncErrNext = 1'b1;
                stateNext    = IDLE;
            end else begin
                msgDataNext   = data;
                msgValidNext  = 1'b1;
                msgStartNext  = first;
                firstNext     = 1'b0;
                msgSeqNumNext = seqNum + {48'd0, msgIdx};
                msgEndNext    = remain == 16'd1;
                remainNext    = remain - 16'd1;
                if (remain == 16'd1) begin
                    msgIdxNext = idxInc;
                    stateNext  = idxInc == msgCnt ? DONE : LEN_HI;
                end
            end
            DONE, DROP: if (!dataValid) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= IDLE;
            offset       <= '0;
            seqNum       <= '0;
            nextSeq      <= '0;
            nextSeqValid <= 1'b0;
            msgCnt       <= '0;
            msgIdx       <= '0;
            remain       <= '0;
            lenHi        <= '0;
            first        <= 1'b0;
            msgSeqNum    <= '0;
            msgData      <= '0;
            msgValid     <= 1'b0;
            msgStart     <= 1'b0;
            msgEnd       <= 1'b0;
            frameDrop    <= 1'b0;
            truncErr     <= 1'b0;
            seqGap       <= 1'b0;
        end else begin
            state        <= stateNext;
            offset       <= offsetNext;
            seqNum       <= seqNumNext;
            nextSeq      <= nextSeqNext;
            nextSeqValid <= nextSeqValidNext;
            msgCnt       <= msgCntNext;
            msgIdx       <= msgIdxNext;
            remain       <= remainNext;
            lenHi        <= lenHiNext;
            first        <= firstNext;
            msgSeqNum    <= msgSeqNumNext;
            msgData      <= msgDataNext;
            msgValid     <= msgValidNext;
            msgStart     <= msgStartNext;
            msgEnd       <= msgEndNext;
            frameDrop    <= frameDropNext;
            truncErr     <= truncErrNext;
            seqGap       <= seqGapNext;
        end
    end
endmodule
